timer_arbiter: RTL and testbench
================================

Name: timer_arbiter

Overview:
Shares a single WIDTH-bit terminal-count timer between N_REQ requesters. Arbitration is round-robin. Each requester supplies its own terminal count and receives a grant for the duration of its timing run. On completion it receives a one-cycle done pulse. The block sits between several control FSMs and the shared delay/tick resource, which it sequences and configures per grant.

Parameters:
N_REQ, 4, number of requesters (legal range 2..16)
WIDTH, 28, counter and terminal-count width in bits
IDX_W, $clog2(N_REQ), width of owner index (derived, not overridden)

Ports:
clk_i    input   1              system clock, all logic on rising edge
rst_i    input   1              synchronous reset, active-high
req_i    input   N_REQ          per-requester request level; bit r = requester r
count_i  input   N_REQ*WIDTH    packed terminal counts; slice [r*WIDTH +: WIDTH] belongs to requester r
gnt_o    output  N_REQ          one-hot grant, high while owner's timer runs
done_o   output  N_REQ          one-cycle completion pulse to the owner
busy_o   output  1              high while in RUN or DONE
owner_o  output  IDX_W          index of current/last granted requester
count_o  output  WIDTH          live timer value

Behaviour:
- Outputs: all outputs are registered.
- Reset: on rst_i high at a clock edge, the block does the following:
  - state <= IDLE;
  - gnt_o, done_o, busy_o, owner_o, count_o, latched target <= 0;
  - round-robin pointer last <= N_REQ-1, so requester 0 has highest priority.
  - Reset wins over every other event, including mid-RUN; no done pulse is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req_i == 0, stay in IDLE; outputs 0 except owner_o, which holds.
  - Otherwise select the first asserted requester searching last+1, last+2, … modulo N_REQ.
  - Next cycle: state RUN; gnt_o[sel]=1; owner_o=sel; last=sel; busy_o=1; count_o=0; target latched from count_i slice sel.
- Latency and target latching:
  - Request-to-grant latency is 1 cycle (req sampled at edge k, gnt_o high after edge k).
  - count_i is sampled only at grant; later changes are ignored for that run.
- RUN:
  - Each cycle, if req_i[owner] == 0, abort: next cycle IDLE, gnt_o=0, busy_o=0, count_o=0, done_o stays 0, last keeps the aborted owner.
  - Else if count_o == target: next cycle DONE, gnt_o=0, done_o[owner]=1, count_o=0.
  - Else count_o <= count_o + 1.
  - Abort check has priority over the terminal check in the same cycle.
  - Grant is high for exactly target+1 cycles, with count_o sequencing 0..target.
  - Done rises target+1 cycles after gnt rises.
- DONE:
  - Lasts exactly 1 cycle: done_o one-hot at owner, busy_o=1, gnt_o=0.
  - Next state is IDLE with done_o=0 and busy_o=0.
  - No arbitration occurs in DONE. Gap between consecutive grants is ≥2 cycles (DONE + IDLE).
- Re-requests: a requester still asserting req_i in IDLE after its done is treated as a new request. Round-robin gives it lowest priority.
- Target edge cases:
  - target = 0: single RUN cycle, then DONE.
  - target = 2^WIDTH-1: full-range run, counter never wraps because terminal is detected first.
- Arithmetic: count_o is unsigned WIDTH-bit, and the compare is full-width equality.
- Grant invariants: gnt_o and done_o are each at most one-hot, and are never high together.
- Request timing: requests asserted or dropped by non-owners during RUN/DONE have no effect until the next IDLE evaluation.

Test Plan:
- Reset: hold rst_i 3 cycles with random req_i -> gnt_o=0, done_o=0, busy_o=0, count_o=0, owner_o=0 every cycle.
- Single run: req_i=4'b0001, count slice0=3 -> after 1 cycle gnt_o=0001 for 4 cycles (count_o 0,1,2,3), then done_o=0001 for 1 cycle, busy_o low the cycle after.
- Simultaneous requests:
  - Stimulus: after reset, req_i=4'b0101 held, targets slice0=2 and slice2=5.
  - Response: grant order 0, 2, 0, 2…; each done pulse lands on the correct bit; gnt_o is never two-hot.
- Zero target: req_i=4'b1000, slice3=0 -> gnt_o=1000 for exactly 1 cycle with count_o=0, done_o=1000 next cycle.
- Abort and count_i change:
  - Stimulus: req1 with slice1=10; at count_o=4 drop req_i[1]; also change slice1 during RUN.
  - Response: next cycle gnt_o=0, count_o=0, busy_o=0, no done_o ever; the count_i change has no effect on the run.
- Reset mid-run: requester 2 running at count_o=5, pulse rst_i -> all outputs 0 next cycle, no done_o. With req_i=0110 afterwards, requester 1 is granted first (pointer restored).

Source files
------------

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin arbiter sharing one terminal-count timer
// Grants the timer to one requester at a time, counts 0..target, then pulses done.
module timer_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 28,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] count_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic [IDX_W-1:0]       owner_o,
  output logic [WIDTH-1:0]       count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic             r_busy;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_last;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_target;

  logic             w_any;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_cand;
  logic [N_REQ-1:0] w_sel_oh;
  logic [N_REQ-1:0] w_owner_oh;
  logic [WIDTH-1:0] w_sel_target;
  logic             w_owner_req;
  logic             w_terminal;

  // Search starts just after the last winner, so it becomes lowest priority.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % N_REQ);
      if (!w_any && req_i[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  assign w_sel_oh     = N_REQ'(1) << w_sel;
  assign w_owner_oh   = N_REQ'(1) << r_owner;
  assign w_sel_target = count_i[int'(w_sel)*WIDTH +: WIDTH];
  assign w_owner_req  = req_i[r_owner];
  assign w_terminal   = (r_count == r_target);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_owner  <= '0;
      r_last   <= IDX_W'(N_REQ - 1);
      r_count  <= '0;
      r_target <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done  <= '0;
          r_count <= '0;
          if (w_any) begin
            r_state  <= ST_RUN;
            r_gnt    <= w_sel_oh;
            r_owner  <= w_sel;
            r_last   <= w_sel;
            r_busy   <= 1'b1;
            r_target <= w_sel_target;
          end else begin
            r_gnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        ST_RUN: begin
          // Dropping the request wins over reaching the terminal count.
          if (!w_owner_req) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
          end else if (w_terminal) begin
            r_state <= ST_DONE;
            r_gnt   <= '0;
            r_done  <= w_owner_oh;
            r_count <= '0;
          end else begin
            r_count <= r_count + WIDTH'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_count <= '0;
        end
      endcase
    end
  end

  assign gnt_o   = r_gnt;
  assign done_o  = r_done;
  assign busy_o  = r_busy;
  assign owner_o = r_owner;
  assign count_o = r_count;

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - self-checking bench for timer_arbiter
module tb_timer_arbiter;

  localparam int N = 4;
  localparam int W = 28;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] cnt = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic [1:0]     owner;
  logic [W-1:0]   count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]      req;
    logic [3:0][7:0] tgt;
    int              n_runs;
    logic [9:0]      owners;
  } vec_t;

  typedef struct {
    logic [1:0] owner;
    int         target;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .count_i(cnt),
    .gnt_o  (gnt),
    .done_o (done),
    .busy_o (busy),
    .owner_o(owner),
    .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && busy !== 1'bx) begin
      n_vec++;
      if ($countones(gnt) > 1 || $countones(done) > 1 || (gnt & done) != 0) begin
        n_err++;
        $display("FAIL invariant: gnt %b done %b expected at most one-hot and disjoint", gnt, done);
      end
    end
  end

  task automatic set_counts(input int t0, input int t1, input int t2, input int t3);
    cnt[0*W +: W] = W'(t0);
    cnt[1*W +: W] = W'(t1);
    cnt[2*W +: W] = W'(t2);
    cnt[3*W +: W] = W'(t3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req = 4'($urandom);
      tick();
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_count", count, 0);
      check("rst_owner", owner, 0);
    end
    req = '0;
    rst = 1'b0;
  endtask

  task automatic add_vec(input logic [3:0] r, input int t0, input int t1, input int t2,
                         input int t3, input int n, input logic [9:0] ow);
    vec_t v;
    v.req    = r;
    v.tgt[0] = 8'(t0);
    v.tgt[1] = 8'(t1);
    v.tgt[2] = 8'(t2);
    v.tgt[3] = 8'(t3);
    v.n_runs = n;
    v.owners = ow;
    vecs.push_back(v);
  endtask

  // Expects the grant one edge after entry (DUT in IDLE), then a full 0..target run and done.
  task automatic run_check();
    exp_t       e;
    logic [3:0] oh;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e  = sb.pop_front();
    oh = 4'b0001 << e.owner;
    tick();
    check("gnt_rise", gnt, oh);
    if (gnt !== oh) return;
    check("owner", owner, e.owner);
    check("busy_run", busy, 1);
    for (int i = 0; i <= e.target; i++) begin
      check("run_count", count, i);
      check("run_gnt", gnt, oh);
      check("run_done", done, 0);
      tick();
    end
    check("done_gnt", gnt, 0);
    check("done_pulse", done, oh);
    check("done_busy", busy, 1);
    check("done_count", count, 0);
    tick();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_gnt", gnt, 0);
  endtask

  initial begin
    exp_t e;
    add_vec(4'b0001, 3, 0, 0, 0, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0});
    add_vec(4'b0101, 2, 0, 5, 0, 4, {2'd0, 2'd2, 2'd0, 2'd2, 2'd0});
    add_vec(4'b1000, 0, 0, 0, 0, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd3});
    add_vec(4'b1111, 1, 2, 3, 4, 5, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0});
    add_vec(4'b0110, 0, 1, 0, 0, 3, {2'd0, 2'd0, 2'd1, 2'd2, 2'd1});

    foreach (vecs[v]) begin
      do_reset();
      set_counts(vecs[v].tgt[0], vecs[v].tgt[1], vecs[v].tgt[2], vecs[v].tgt[3]);
      req = vecs[v].req;
      for (int k = 0; k < vecs[v].n_runs; k++) begin
        e.owner  = vecs[v].owners[2*k +: 2];
        e.target = int'(vecs[v].tgt[e.owner]);
        sb.push_back(e);
      end
      while (sb.size() > 0) run_check();
      req = '0;
      tick();
      check("idle_gnt", gnt, 0);
      check("idle_busy", busy, 0);
    end

    // Abort at count 4 with a mid-run count_i change; last pointer keeps the aborted owner.
    do_reset();
    set_counts(0, 10, 0, 0);
    req = 4'b0010;
    tick();
    check("ab_gnt", gnt, 4'b0010);
    check("ab_count0", count, 0);
    set_counts(0, 2, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("ab_count", count, i);
      check("ab_gnt_hold", gnt, 4'b0010);
      check("ab_no_done", done, 0);
    end
    req = 4'b0000;
    tick();
    check("ab_gnt_off", gnt, 0);
    check("ab_count_clr", count, 0);
    check("ab_busy_off", busy, 0);
    check("ab_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab_no_done_late", done, 0);
      check("ab_idle_gnt", gnt, 0);
    end
    req = 4'b0011;
    e.owner = 2'd0; e.target = 0; sb.push_back(e);
    run_check();
    req = '0;
    tick();

    // Reset during a run, then the pointer must favour requester 0 onward again.
    do_reset();
    set_counts(0, 1, 8, 0);
    req = 4'b0100;
    tick();
    check("mr_gnt", gnt, 4'b0100);
    repeat (5) tick();
    check("mr_count5", count, 5);
    rst = 1'b1;
    tick();
    check("mr_gnt_clr", gnt, 0);
    check("mr_done_clr", done, 0);
    check("mr_busy_clr", busy, 0);
    check("mr_count_clr", count, 0);
    check("mr_owner_clr", owner, 0);
    rst = 1'b0;
    req = 4'b0110;
    e.owner = 2'd1; e.target = 1; sb.push_back(e);
    e.owner = 2'd2; e.target = 8; sb.push_back(e);
    while (sb.size() > 0) run_check();
    req = '0;
    tick();
    check("mr_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
